// File: rtl/gru_seq_engine.sv
// gru_seq_engine: time-multiplexed GRU cell with one MAC and an internal weight file.
// Streams input vectors in and hidden vectors out across multi-step sequences.
module gru_seq_engine #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int IN_SIZE    = 4,
    parameter int HID_SIZE   = 2,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
    parameter int ADDR_W     = $clog2(3 * HID_SIZE * (IN_SIZE + HID_SIZE + 2))
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [WIDTH-1:0]          cfg_wdata,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic [IN_SIZE*WIDTH-1:0]  x_data,
    input  logic                      x_last,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [HID_SIZE*WIDTH-1:0] y_data,
    output logic                      y_last,
    output logic                      busy
);
    localparam int NREG  = 3 * HID_SIZE * (IN_SIZE + HID_SIZE + 2);
    localparam int WH    = 3 * IN_SIZE * HID_SIZE;
    localparam int BI    = WH + 3 * HID_SIZE * HID_SIZE;
    localparam int BH    = BI + 3 * HID_SIZE;
    localparam int ACC_W = 2 * WIDTH + $clog2(IN_SIZE + HID_SIZE + 2);
    localparam int CNT_W = $clog2(IN_SIZE + HID_SIZE + 1);
    localparam int J_W   = (HID_SIZE > 1) ? $clog2(HID_SIZE) : 1;
    localparam int ONE   = 1 << FRAC_WIDTH;

    typedef logic signed [WIDTH-1:0]   word_t;
    typedef logic signed [WIDTH:0]     wide_t;
    typedef logic signed [2*WIDTH-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]   acc_t;
    typedef enum logic [2:0] {
        S_IDLE, S_ACC_R, S_ACC_Z, S_ACC_NI, S_ACC_NH, S_UPD, S_COMMIT, S_OUT
    } state_t;

    function automatic word_t sat(input acc_t v);
        acc_t hi;
        acc_t lo;
        hi = acc_t'({1'b0, {(WIDTH-1){1'b1}}});
        lo = ~hi;
        if (v > hi) return hi[WIDTH-1:0];
        if (v < lo) return lo[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    function automatic word_t q(input acc_t v);
        return sat(v >>> FRAC_WIDTH);
    endfunction

    function automatic word_t fxmul(input word_t a, input wide_t b);
        acc_t p;
        p = acc_t'(a) * acc_t'(b);
        return sat(p >>> FRAC_WIDTH);
    endfunction

    function automatic word_t hsig(input word_t v);
        wide_t t;
        t = wide_t'(v >>> 2) + wide_t'(ONE / 2);
        if (t[WIDTH]) return '0;
        if (t > wide_t'(ONE)) return word_t'(ONE);
        return t[WIDTH-1:0];
    endfunction

    function automatic word_t htanh(input word_t v);
        if (v > word_t'(ONE)) return word_t'(ONE);
        if (v < -word_t'(ONE)) return -word_t'(ONE);
        return v;
    endfunction

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          k_q, k_d;
    logic [J_W-1:0]            j_q, j_d;
    word_t                     rf_q [NREG];
    word_t                     rf_d [NREG];
    word_t                     x_q [IN_SIZE];
    word_t                     x_d [IN_SIZE];
    word_t                     h_q [HID_SIZE];
    word_t                     h_d [HID_SIZE];
    word_t                     h_new_q [HID_SIZE];
    word_t                     h_new_d [HID_SIZE];
    logic                      x_last_q, x_last_d;
    acc_t                      acc_r_q, acc_r_d, acc_z_q, acc_z_d;
    acc_t                      acc_ni_q, acc_ni_d, acc_nh_q, acc_nh_d;
    logic [HID_SIZE*WIDTH-1:0] y_data_q, y_data_d;
    logic                      y_valid_q, y_valid_d;
    logic                      y_last_q, y_last_d;

    word_t w_sel, a_sel;
    acc_t  init, cur, mac;
    prod_t prod;
    word_t r_g, z_g, n_g, h_upd;
    wide_t diff;

    // Operand steering for the single MAC: gate G, element k, hidden unit j.
    always_comb begin
        int g;
        int ki;
        int ji;
        int hk;
        logic use_x;
        ki    = int'(k_q);
        ji    = int'(j_q);
        g     = 0;
        cur   = '0;
        init  = '0;
        use_x = 1'b1;
        unique case (state_q)
            S_ACC_R:  begin g = 0; use_x = (ki < IN_SIZE); cur = acc_r_q; end
            S_ACC_Z:  begin g = 1; use_x = (ki < IN_SIZE); cur = acc_z_q; end
            S_ACC_NI: begin g = 2; cur = acc_ni_q; end
            S_ACC_NH: begin g = 2; use_x = 1'b0; cur = acc_nh_q; end
            default:  begin g = 0; end
        endcase
        hk = (state_q == S_ACC_NH) ? ki : ki - IN_SIZE;
        if (use_x)
            w_sel = rf_q[ADDR_W'(g * IN_SIZE * HID_SIZE + ki * HID_SIZE + ji)];
        else
            w_sel = rf_q[ADDR_W'(WH + g * HID_SIZE * HID_SIZE + hk * HID_SIZE + ji)];
        a_sel = '0;
        for (int i = 0; i < IN_SIZE; i++)
            if (use_x && ki == i) a_sel = x_q[i];
        for (int k = 0; k < HID_SIZE; k++)
            if (!use_x && hk == k) a_sel = h_q[k];
        unique case (state_q)
            S_ACC_NI: init = acc_t'(rf_q[ADDR_W'(BI + g * HID_SIZE + ji)]);
            S_ACC_NH: init = acc_t'(rf_q[ADDR_W'(BH + g * HID_SIZE + ji)]);
            default:  init = acc_t'(rf_q[ADDR_W'(BI + g * HID_SIZE + ji)])
                           + acc_t'(rf_q[ADDR_W'(BH + g * HID_SIZE + ji)]);
        endcase
        prod = prod_t'(w_sel) * prod_t'(a_sel);
        mac  = ((k_q == '0) ? (init <<< FRAC_WIDTH) : cur) + acc_t'(prod);
    end

    always_comb begin
        r_g   = hsig(q(acc_r_q));
        z_g   = hsig(q(acc_z_q));
        n_g   = htanh(sat(acc_t'(q(acc_ni_q))
                    + acc_t'(fxmul(r_g, wide_t'(q(acc_nh_q))))));
        diff  = wide_t'(h_q[j_q]) - wide_t'(n_g);
        h_upd = sat(acc_t'(n_g) + acc_t'(fxmul(z_g, diff)));
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        j_d       = j_q;
        rf_d      = rf_q;
        x_d       = x_q;
        h_d       = h_q;
        h_new_d   = h_new_q;
        x_last_d  = x_last_q;
        acc_r_d   = acc_r_q;
        acc_z_d   = acc_z_q;
        acc_ni_d  = acc_ni_q;
        acc_nh_d  = acc_nh_q;
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        y_last_d  = y_last_q;
        if (cfg_we && state_q == S_IDLE && {1'b0, cfg_addr} < (ADDR_W+1)'(NREG))
            rf_d[cfg_addr] = cfg_wdata;
        unique case (state_q)
            S_IDLE: if (x_valid) begin
                for (int i = 0; i < IN_SIZE; i++)
                    x_d[i] = x_data[i*WIDTH +: WIDTH];
                x_last_d = x_last;
                k_d      = '0;
                j_d      = '0;
                state_d  = S_ACC_R;
            end
            S_ACC_R: begin
                acc_r_d = mac;
                k_d     = k_q + CNT_W'(1);
                if (k_q == CNT_W'(IN_SIZE + HID_SIZE - 1)) begin
                    k_d = '0; state_d = S_ACC_Z;
                end
            end
            S_ACC_Z: begin
                acc_z_d = mac;
                k_d     = k_q + CNT_W'(1);
                if (k_q == CNT_W'(IN_SIZE + HID_SIZE - 1)) begin
                    k_d = '0; state_d = S_ACC_NI;
                end
            end
            S_ACC_NI: begin
                acc_ni_d = mac;
                k_d      = k_q + CNT_W'(1);
                if (k_q == CNT_W'(IN_SIZE - 1)) begin
                    k_d = '0; state_d = S_ACC_NH;
                end
            end
            S_ACC_NH: begin
                acc_nh_d = mac;
                k_d      = k_q + CNT_W'(1);
                if (k_q == CNT_W'(HID_SIZE - 1)) begin
                    k_d = '0; state_d = S_UPD;
                end
            end
            S_UPD: begin
                h_new_d[j_q] = h_upd;
                if (j_q == J_W'(HID_SIZE - 1)) state_d = S_COMMIT;
                else begin
                    j_d = j_q + J_W'(1); state_d = S_ACC_R;
                end
            end
            // A finished sequence leaves zero state for the next one.
            S_COMMIT: begin
                for (int j = 0; j < HID_SIZE; j++) begin
                    y_data_d[j*WIDTH +: WIDTH] = h_new_q[j];
                    h_d[j] = x_last_q ? '0 : h_new_q[j];
                end
                y_last_d  = x_last_q;
                y_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: if (y_ready) begin
                y_valid_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            j_q       <= '0;
            rf_q      <= '{default: '0};
            x_q       <= '{default: '0};
            h_q       <= '{default: '0};
            h_new_q   <= '{default: '0};
            x_last_q  <= 1'b0;
            acc_r_q   <= '0;
            acc_z_q   <= '0;
            acc_ni_q  <= '0;
            acc_nh_q  <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            rf_q      <= rf_d;
            x_q       <= x_d;
            h_q       <= h_d;
            h_new_q   <= h_new_d;
            x_last_q  <= x_last_d;
            acc_r_q   <= acc_r_d;
            acc_z_q   <= acc_z_d;
            acc_ni_q  <= acc_ni_d;
            acc_nh_q  <= acc_nh_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
        end
    end

    assign x_ready = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_last  = y_last_q;
endmodule

// File: tb/tb_gru_seq_engine.sv
// Bench for gru_seq_engine: expected hidden vectors are queued per step
// and compared when the engine presents each output.
module tb_gru_seq_engine;
    localparam int W   = 17;
    localparam int IN  = 4;
    localparam int HID = 2;
    localparam int AW  = 6;
    localparam int LAT = 39;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [W-1:0]    cfg_wdata;
    logic            x_valid;
    logic            x_ready;
    logic [IN*W-1:0] x_data;
    logic            x_last;
    logic            y_valid;
    logic            y_ready;
    logic [HID*W-1:0] y_data;
    logic            y_last;
    logic            busy;

    gru_seq_engine dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HID*W-1:0] d;
        logic             l;
    } exp_t;
    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [AW-1:0] a_wi(input int g, input int i, input int j);
        return AW'(g * IN * HID + i * HID + j);
    endfunction
    function automatic logic [AW-1:0] a_wh(input int g, input int k, input int j);
        return AW'(3 * IN * HID + g * HID * HID + k * HID + j);
    endfunction
    function automatic logic [AW-1:0] a_bi(input int g, input int j);
        return AW'(3 * IN * HID + 3 * HID * HID + g * HID + j);
    endfunction
    function automatic logic [AW-1:0] a_bh(input int g, input int j);
        return AW'(3 * IN * HID + 3 * HID * HID + 3 * HID + g * HID + j);
    endfunction
    function automatic logic [HID*W-1:0] pack2(input int h0, input int h1);
        return {W'(h1), W'(h0)};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cfg_wr(input logic [AW-1:0] a, input int d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = W'(d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_x(input int x0, input int x1, input int x2, input int x3);
        x_data = {W'(x3), W'(x2), W'(x1), W'(x0)};
    endtask

    task automatic hs(input logic last);
        chk("x_ready_idle", x_ready, 1);
        x_valid = 1'b1; x_last = last;
        @(posedge clk); #1;
        x_valid = 1'b0; x_last = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (y_valid !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, ".lat"}, cnt, LAT);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".data"}, y_data, e.d);
            chk({tag, ".last"}, y_last, e.l);
        end else begin
            chk({tag, ".sb_underflow"}, 1, 0);
        end
    endtask

    task automatic release_y(input string tag);
        y_ready = 1'b1;
        @(posedge clk); #1;
        y_ready = 1'b0;
        chk({tag, ".drain"}, y_valid, 0);
    endtask

    task automatic step(input string tag, input int x0, input int x1, input int x2,
                        input int x3, input logic last, input int e0, input int e1);
        set_x(x0, x1, x2, x3);
        sb.push_back('{pack2(e0, e1), last});
        hs(last);
        wait_out(tag);
        release_y(tag);
    endtask

    task automatic force_z0();
        for (int j = 0; j < HID; j++) begin
            cfg_wr(a_bi(1, j), -1024);
            cfg_wr(a_bh(1, j), -1024);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        x_valid = 1'b0; x_data = '0; x_last = 1'b0; y_ready = 1'b0;
        do_reset();
        chk("rst.x_ready", x_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.y_valid", y_valid, 0);
        chk("rst.y_data", y_data, 0);
        chk("rst.y_last", y_last, 0);

        step("t1_zero", 100, -50, 7, 0, 1'b0, 0, 0);

        do_reset();
        force_z0();
        for (int j = 0; j < HID; j++) cfg_wr(a_bi(2, j), 128);
        step("t2_bin128", 0, 0, 0, 0, 1'b0, 128, 128);
        for (int j = 0; j < HID; j++) cfg_wr(a_bi(2, j), 1024);
        step("t2_tanh_clamp", 0, 0, 0, 0, 1'b0, 256, 256);

        for (int j = 0; j < HID; j++) cfg_wr(a_bi(2, j), 128);
        set_x(0, 0, 0, 0);
        sb.push_back('{pack2(256, 128), 1'b0});
        cfg_we = 1'b1; cfg_addr = a_bi(2, 0); cfg_wdata = W'(1024);
        x_valid = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; x_valid = 1'b0;
        wait_out("t2_cfg_same_cycle");
        release_y("t2_cfg_same_cycle");

        set_x(0, 0, 0, 0);
        sb.push_back('{pack2(256, 128), 1'b0});
        hs(1'b0);
        wait_out("t4_bp");
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin
                cfg_we = 1'b1; cfg_addr = a_bi(2, 1); cfg_wdata = W'(1024);
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            chk("t4_bp.y_valid", y_valid, 1);
            chk("t4_bp.y_data", y_data, pack2(256, 128));
            chk("t4_bp.y_last", y_last, 0);
            chk("t4_bp.x_ready", x_ready, 0);
            chk("t4_bp.busy", busy, 1);
        end
        release_y("t4_bp");
        step("t4_after_bp", 0, 0, 0, 0, 1'b0, 256, 128);

        do_reset();
        force_z0();
        for (int j = 0; j < HID; j++) begin
            cfg_wr(a_bh(0, j), 1024);
            cfg_wr(a_wi(2, 0, j), 256);
            for (int k = 0; k < HID; k++) cfg_wr(a_wh(2, k, j), 256);
        end
        step("t3_s0", 64, 0, 0, 0, 1'b0, 64, 64);
        step("t3_s1", 0, 0, 0, 0, 1'b0, 128, 128);
        step("t3_s2", 0, 0, 0, 0, 1'b0, 256, 256);
        step("t3_s3", 0, 0, 0, 0, 1'b1, 256, 256);
        step("t3_r0", 64, 0, 0, 0, 1'b0, 64, 64);
        step("t3_r1", 0, 0, 0, 0, 1'b1, 128, 128);
        step("t3_r2", 0, 0, 0, 0, 1'b0, 0, 0);

        do_reset();
        force_z0();
        for (int i = 0; i < IN; i++)
            for (int j = 0; j < HID; j++) cfg_wr(a_wi(2, i, j), 65535);
        step("t5_sat", 65535, 65535, 65535, 65535, 1'b0, 256, 256);

        do_reset();
        force_z0();
        for (int j = 0; j < HID; j++) cfg_wr(a_bi(2, j), 128);
        set_x(5, 5, 5, 5);
        hs(1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6.x_ready", x_ready, 1);
        chk("t6.busy", busy, 0);
        chk("t6.y_valid", y_valid, 0);
        chk("t6.y_data", y_data, 0);
        step("t6_after", 100, -50, 7, 3, 1'b0, 0, 0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gru_seq_engine.md
Name: gru_seq_engine

Overview:
Parametrised, time-multiplexed GRU cell engine. It replaces the fixed 4-input/2-hidden, fully parallel GRU instance with a design that has these features:
- a single-MAC datapath;
- an internal weight/bias register file loaded through a config port;
- a hidden-state feedback register;
- valid/ready streaming of input vectors and output hidden vectors across multi-step sequences.

It sits between the sample source and the downstream consumer in the inference pipeline.

Parameters:
INT_WIDTH, 8, integer bits of signed fixed-point word
FRAC_WIDTH, 8, fractional bits; WIDTH = INT_WIDTH+FRAC_WIDTH+1 (17 by default), 1.0 = 2^FRAC_WIDTH
IN_SIZE, 4, input vector length
HID_SIZE, 2, hidden vector length
ADDR_W, $clog2(3*HID_SIZE*(IN_SIZE+HID_SIZE+2)), config address width (6 by default)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  weight/bias write strobe
cfg_addr  in  ADDR_W  write address (map below)
cfg_wdata  in  WIDTH  signed write data
x_valid  in  1  input vector valid
x_ready  out  1  engine can accept an input vector
x_data  in  IN_SIZE*WIDTH  element i at [i*WIDTH +: WIDTH]
x_last  in  1  marks the final step of a sequence
y_valid  out  1  output vector valid
y_ready  in  1  consumer accepts output
y_data  out  HID_SIZE*WIDTH  h_new[j] at [j*WIDTH +: WIDTH]
y_last  out  1  copy of x_last for this step
busy  out  1  high in every state except IDLE

Behaviour:
- Clocking/reset:
  - One clock, clk. reset is synchronous and active-high.
  - Reset forces state IDLE. It clears h, h_new, accumulators, the register file, y_data, y_valid and y_last to 0.
  - Reset overrides any operation in progress, at any state.
- Address map, gate index G: r=0, z=1, n=2.
  - W_i[G][i][j] at G*IN*HID + i*HID + j.
  - WH base = 3*IN*HID. W_h[G][k][j] at WH + G*HID*HID + k*HID + j.
  - BI base = WH + 3*HID*HID. b_i[G][j] at BI + G*HID + j.
  - BH base = BI + 3*HID. b_h[G][j] at BH + G*HID + j.
- Config writes:
  - Accepted only when busy=0.
  - Ignored when busy=1 and when the address is at or above 3*HID*(IN+HID+2).
  - A write and an x handshake in the same cycle: the write takes effect, and the step uses the new value.
- Handshakes:
  - x_ready = (state==IDLE). On x_valid & x_ready, latch x_data and x_last, then go to state ACC_R with j=0.
  - y_valid holds, with y_data and y_last stable, until y_ready. Then go to IDLE.
- Per hidden unit j, the states run ACC_R (IN+HID cycles), ACC_Z (IN+HID), ACC_NI (IN), ACC_NH (HID), UPD (1).
  - After UPD: if j<HID-1, increment j and go to ACC_R. Otherwise go to COMMIT (1 cycle), then OUT.
- Latency: y_valid rises exactly L = HID*(3*(IN+HID)+1)+1 cycles after the x handshake edge (39 cycles by default). y_ready does not affect this.
- MAC and accumulator:
  - Accumulator width is 2*WIDTH+$clog2(IN+HID+2), signed.
  - ACC_R/ACC_Z start from (b_i+b_h)<<FRAC. ACC_NI starts from b_in<<FRAC. ACC_NH starts from b_hn<<FRAC.
  - Each cycle adds the full-precision product of one weight and one x or h element.
- Helper operations:
  - sat() clamps to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
  - q(acc) = sat(acc>>>FRAC), an arithmetic shift that floors.
  - fxmul(a,b) = sat((a*b)>>>FRAC).
  - hsig(v) = clamp((v>>>2) + 2^(FRAC-1), 0, 2^FRAC).
  - htanh(v) = clamp(v, -2^FRAC, 2^FRAC).
- UPD, computed combinationally and registered into h_new[j]:
  - r = hsig(q(acc_r)); z = hsig(q(acc_z)).
  - n = htanh(sat(q(acc_ni) + fxmul(r, q(acc_nh)))).
  - h_new[j] = sat(n + fxmul(z, h[j]-n)). h[j]-n is evaluated at WIDTH+1 bits.
- h is not modified until COMMIT, so every j uses the previous h.
- COMMIT:
  - y_data <= h_new; y_last <= latched x_last.
  - h <= h_new, or h <= 0 if latched x_last=1, so the next sequence starts from zero state.

Test Plan:
(defaults; 1.0 = 256)
1. After reset with all-zero weights, send x = {100,-50,7,0}: y_data = {0,0} and y_valid rises exactly 39 cycles after the handshake.
2. Set b_iz[j] = b_hz[j] = -1024 (forcing z=0) and b_in[j] = 128, all else 0; send x = 0: y = {128,128}. Then set b_in[j] = 1024: y = {256,256} (tanh clamp).
3. Recurrence setup: z forced to 0 as in test 2; b_hr[j] = 1024 (r=1); w_hn all 256, w_in[0][j] = 256; all other terms 0.
   - Step x0=64 gives y = {64,64}.
   - Then x=0 gives {128,128}, then {256,256}, then {256,256}.
   - Repeat with x_last=1 on step 2: y_last=1, and the following step with x=0 gives {0,0}.
4. Backpressure: hold y_ready=0 for 10 cycles after y_valid. Required: y_data and y_last stable, x_ready=0, busy=1, and a cfg write in that window does not change the next result.
5. Saturation: w_in all 65535, x all 65535, z forced 0: n saturates, y = {256,256}, no wrap to a negative value.
6. Reset mid-step: assert reset 10 cycles after the x handshake. The next cycle shows x_ready=1, busy=0, y_valid=0, and the register file cleared; a following step with any x yields {0,0}.
